// File: rtl/clock_24hr_multimode.sv
// BCD 24-hour clock with DST adjust, 12/24h display, validated time load and a
// timed alarm, all clocked from the kHz system clock.
module clock_24hr_multimode #(
    parameter int unsigned TICKS_PER_SEC = 1000,
    parameter logic [23:0] RESET_TIME    = 24'h000000,
    parameter int unsigned ALARM_LEN_SEC = 10
) (
    input  logic        kh_clk,
    input  logic        reset,
    input  logic        spring_szn,
    input  logic        mode_12h,
    input  logic        set_en,
    input  logic [23:0] set_time,
    input  logic        alarm_en,
    input  logic [23:0] alarm_time,
    output logic [23:0] disp_time,
    output logic        pm,
    output logic        sec_tick,
    output logic        set_err,
    output logic        alarm
);

    localparam int unsigned PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned ACNT_W  = $clog2(ALARM_LEN_SEC + 1);
    localparam logic [PRESC_W-1:0] PRESC_TERM = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [ACNT_W-1:0]  ALARM_LOAD = ACNT_W'(ALARM_LEN_SEC);

    function automatic logic [7:0] inc_mod60(input logic [7:0] v);
        if (v == 8'h59)       return 8'h00;
        if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] hour_inc(input logic [7:0] v);
        if (v == 8'h23)       return 8'h00;
        if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] hour_dec(input logic [7:0] v);
        if (v == 8'h00)       return 8'h23;
        if (v[3:0] == 4'd0)   return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic digits_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic time_valid(input logic [23:0] t);
        return digits_ok(t[23:16]) && digits_ok(t[15:8]) && digits_ok(t[7:0]) &&
               (t[23:16] <= 8'h23) && (t[15:8] <= 8'h59) && (t[7:0] <= 8'h59);
    endfunction

    logic [23:0]        time_q, time_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               dst_prev_q;
    logic               match_q;
    logic [ACNT_W-1:0]  acnt_q, acnt_d;
    logic               sec_tick_d, set_err_d, alarm_d;
    logic               tick_c, set_ok_c, dst_rise_c, dst_fall_c, match_c;
    logic [7:0]         hh_n, mm_n, ss_n;

    assign tick_c     = (presc_q == PRESC_TERM);
    assign set_ok_c   = set_en && time_valid(set_time);
    assign dst_rise_c = spring_szn && !dst_prev_q;
    assign dst_fall_c = !spring_szn && dst_prev_q;
    assign match_c    = (time_q == alarm_time);

    // Time/prescaler next state: a valid load wins; otherwise carry first, then DST.
    always_comb begin
        hh_n       = time_q[23:16];
        mm_n       = time_q[15:8];
        ss_n       = time_q[7:0];
        presc_d    = tick_c ? '0 : presc_q + PRESC_W'(1);
        sec_tick_d = 1'b0;
        set_err_d  = 1'b0;
        time_d     = time_q;
        if (set_ok_c) begin
            time_d  = set_time;
            presc_d = '0;
        end else begin
            set_err_d  = set_en;
            sec_tick_d = tick_c;
            if (tick_c) begin
                ss_n = inc_mod60(time_q[7:0]);
                if (time_q[7:0] == 8'h59) begin
                    mm_n = inc_mod60(time_q[15:8]);
                    if (time_q[15:8] == 8'h59) hh_n = hour_inc(time_q[23:16]);
                end
            end
            if (dst_rise_c)      hh_n = hour_inc(hh_n);
            else if (dst_fall_c) hh_n = hour_dec(hh_n);
            time_d = {hh_n, mm_n, ss_n};
        end
    end

    // Alarm: fires on the first cycle the stored time equals alarm_time.
    always_comb begin
        alarm_d = alarm;
        acnt_d  = acnt_q;
        if (!alarm_en) begin
            alarm_d = 1'b0;
            acnt_d  = '0;
        end else if (match_c && !match_q) begin
            alarm_d = 1'b1;
            acnt_d  = ALARM_LOAD;
        end else if (alarm && sec_tick) begin
            acnt_d = acnt_q - ACNT_W'(1);
            if (acnt_q == ACNT_W'(1)) alarm_d = 1'b0;
        end
    end

    always_ff @(posedge kh_clk or negedge reset) begin
        if (!reset) begin
            time_q     <= RESET_TIME;
            presc_q    <= '0;
            dst_prev_q <= 1'b0;
            match_q    <= 1'b0;
            acnt_q     <= '0;
            sec_tick   <= 1'b0;
            set_err    <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            time_q     <= time_d;
            presc_q    <= presc_d;
            dst_prev_q <= spring_szn;
            match_q    <= match_c;
            acnt_q     <= acnt_d;
            sec_tick   <= sec_tick_d;
            set_err    <= set_err_d;
            alarm      <= alarm_d;
        end
    end

    logic [7:0] hh_disp_c;
    logic [4:0] hh_bin_c, hh_sub_c;

    // 12-hour mapping: 00 -> 12, 13..23 -> hh-12 via a small binary detour.
    always_comb begin
        hh_bin_c  = 5'(time_q[23:20]) * 5'd10 + 5'(time_q[19:16]);
        hh_sub_c  = hh_bin_c - 5'd12;
        hh_disp_c = time_q[23:16];
        if (mode_12h) begin
            if (time_q[23:16] == 8'h00) begin
                hh_disp_c = 8'h12;
            end else if (time_q[23:16] > 8'h12) begin
                if (hh_sub_c >= 5'd10) hh_disp_c = {4'd1, 4'(hh_sub_c - 5'd10)};
                else                   hh_disp_c = {4'd0, 4'(hh_sub_c)};
            end
        end
    end

    assign disp_time = {hh_disp_c, time_q[15:0]};
    assign pm        = (time_q[23:16] >= 8'h12);

endmodule

// File: tb/tb_clock_24hr_multimode.sv
// Directed bench for clock_24hr_multimode with 4 ticks/second and a 3-second alarm.
module tb_clock_24hr_multimode;

    logic        kh_clk;
    logic        reset;
    logic        spring_szn;
    logic        mode_12h;
    logic        set_en;
    logic [23:0] set_time;
    logic        alarm_en;
    logic [23:0] alarm_time;
    logic [23:0] disp_time;
    logic        pm;
    logic        sec_tick;
    logic        set_err;
    logic        alarm;

    int errors = 0;
    int checks = 0;

    clock_24hr_multimode #(
        .TICKS_PER_SEC(4),
        .RESET_TIME   (24'h235959),
        .ALARM_LEN_SEC(3)
    ) dut (
        .kh_clk    (kh_clk),
        .reset     (reset),
        .spring_szn(spring_szn),
        .mode_12h  (mode_12h),
        .set_en    (set_en),
        .set_time  (set_time),
        .alarm_en  (alarm_en),
        .alarm_time(alarm_time),
        .disp_time (disp_time),
        .pm        (pm),
        .sec_tick  (sec_tick),
        .set_err   (set_err),
        .alarm     (alarm)
    );

    initial kh_clk = 1'b0;
    always #5 kh_clk = ~kh_clk;

    task automatic step();
        @(posedge kh_clk);
        #1;
    endtask

    task automatic do_set(input logic [23:0] v);
        set_time = v;
        set_en   = 1'b1;
        step();
        set_en   = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if (disp_time !== 24'h235959 || pm !== 1'b1) begin
            errors++;
            $display("FAIL reset_time: got %h pm=%b expected 235959 pm=1", disp_time, pm);
        end
        checks++;
        if (sec_tick !== 1'b0 || set_err !== 1'b0 || alarm !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got tick=%b err=%b alarm=%b expected 0 0 0", sec_tick, set_err, alarm);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (sec_tick !== 1'b0 || disp_time !== 24'h235959) begin
                errors++;
                $display("FAIL pre_tick_%0d: got tick=%b disp=%h expected 0 235959", i, sec_tick, disp_time);
            end
        end
        step();
        checks++;
        if (sec_tick !== 1'b1 || disp_time !== 24'h000000 || pm !== 1'b0) begin
            errors++;
            $display("FAIL midnight_wrap: got tick=%b disp=%h pm=%b expected 1 000000 0", sec_tick, disp_time, pm);
        end
        step();
        checks++;
        if (sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL tick_pulse_width: got %b expected 0", sec_tick);
        end
    endtask

    task automatic test_dst();
        do_set(24'h013000);
        spring_szn = 1'b1;
        step();
        checks++;
        if (disp_time !== 24'h023000) begin
            errors++;
            $display("FAIL dst_spring: got %h expected 023000", disp_time);
        end
        do_set(24'h001000);
        checks++;
        if (disp_time !== 24'h001000) begin
            errors++;
            $display("FAIL dst_level_hold: got %h expected 001000", disp_time);
        end
        spring_szn = 1'b0;
        step();
        checks++;
        if (disp_time !== 24'h231000 || pm !== 1'b1) begin
            errors++;
            $display("FAIL dst_fall_wrap: got %h pm=%b expected 231000 pm=1", disp_time, pm);
        end
    endtask

    task automatic test_dst_tick();
        do_set(24'h015959);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (disp_time !== 24'h015959) begin
                errors++;
                $display("FAIL dst_tick_hold_%0d: got %h expected 015959", i, disp_time);
            end
        end
        spring_szn = 1'b1;
        step();
        checks++;
        if (disp_time !== 24'h030000 || sec_tick !== 1'b1) begin
            errors++;
            $display("FAIL dst_tick_combo: got %h tick=%b expected 030000 tick=1", disp_time, sec_tick);
        end
    endtask

    task automatic test_12h();
        mode_12h = 1'b1;
        do_set(24'h000500);
        checks++;
        if (disp_time !== 24'h120500 || pm !== 1'b0) begin
            errors++;
            $display("FAIL h12_midnight: got %h pm=%b expected 120500 pm=0", disp_time, pm);
        end
        do_set(24'h120000);
        checks++;
        if (disp_time !== 24'h120000 || pm !== 1'b1) begin
            errors++;
            $display("FAIL h12_noon: got %h pm=%b expected 120000 pm=1", disp_time, pm);
        end
        do_set(24'h230102);
        checks++;
        if (disp_time !== 24'h110102 || pm !== 1'b1) begin
            errors++;
            $display("FAIL h12_23h: got %h pm=%b expected 110102 pm=1", disp_time, pm);
        end
        do_set(24'h091111);
        checks++;
        if (disp_time !== 24'h091111 || pm !== 1'b0) begin
            errors++;
            $display("FAIL h12_morning: got %h pm=%b expected 091111 pm=0", disp_time, pm);
        end
        do_set(24'h134510);
        checks++;
        if (disp_time !== 24'h014510 || pm !== 1'b1) begin
            errors++;
            $display("FAIL h12_afternoon: got %h pm=%b expected 014510 pm=1", disp_time, pm);
        end
        mode_12h = 1'b0;
        #1;
        checks++;
        if (disp_time !== 24'h134510 || pm !== 1'b1) begin
            errors++;
            $display("FAIL h24_afternoon: got %h pm=%b expected 134510 pm=1", disp_time, pm);
        end
    endtask

    task automatic test_set();
        do_set(24'h246000);
        checks++;
        if (set_err !== 1'b1 || disp_time !== 24'h134510) begin
            errors++;
            $display("FAIL set_bad_range: got err=%b disp=%h expected 1 134510", set_err, disp_time);
        end
        do_set(24'h1A0000);
        checks++;
        if (set_err !== 1'b1 || disp_time !== 24'h134510) begin
            errors++;
            $display("FAIL set_bad_digit: got err=%b disp=%h expected 1 134510", set_err, disp_time);
        end
        do_set(24'h235958);
        checks++;
        if (set_err !== 1'b0 || disp_time !== 24'h235958) begin
            errors++;
            $display("FAIL set_good: got err=%b disp=%h expected 0 235958", set_err, disp_time);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (sec_tick !== 1'b0 || disp_time !== 24'h235958) begin
                errors++;
                $display("FAIL set_presc_clear_%0d: got tick=%b disp=%h expected 0 235958", i, sec_tick, disp_time);
            end
        end
        step();
        checks++;
        if (sec_tick !== 1'b1 || disp_time !== 24'h235959) begin
            errors++;
            $display("FAIL set_first_tick: got tick=%b disp=%h expected 1 235959", sec_tick, disp_time);
        end
        spring_szn = 1'b0;
        do_set(24'h100000);
        checks++;
        if (disp_time !== 24'h100000) begin
            errors++;
            $display("FAIL set_masks_dst: got %h expected 100000", disp_time);
        end
        step();
        checks++;
        if (disp_time !== 24'h100000) begin
            errors++;
            $display("FAIL set_dst_discarded: got %h expected 100000", disp_time);
        end
        spring_szn = 1'b1;
        do_set(24'h006000);
        checks++;
        if (set_err !== 1'b1 || disp_time !== 24'h110000) begin
            errors++;
            $display("FAIL bad_set_keeps_dst: got err=%b disp=%h expected 1 110000", set_err, disp_time);
        end
        step();
        checks++;
        if (set_err !== 1'b0) begin
            errors++;
            $display("FAIL set_err_pulse: got %b expected 0", set_err);
        end
    endtask

    task automatic reach_alarm();
        do_set(24'h055959);
        for (int i = 0; i < 3; i++) step();
        step();
        checks++;
        if (disp_time !== 24'h060000 || alarm !== 1'b0) begin
            errors++;
            $display("FAIL alarm_arrive: got disp=%h alarm=%b expected 060000 0", disp_time, alarm);
        end
        step();
        checks++;
        if (alarm !== 1'b1) begin
            errors++;
            $display("FAIL alarm_trigger: got %b expected 1", alarm);
        end
    endtask

    task automatic test_alarm();
        int  high;
        int  ticks;
        bit  fell;
        alarm_time = 24'h060000;
        alarm_en   = 1'b1;
        reach_alarm();
        high  = 0;
        ticks = 0;
        fell  = 1'b0;
        for (int i = 0; i < 40 && !fell; i++) begin
            if (alarm === 1'b1) begin
                high++;
                if (sec_tick === 1'b1) ticks++;
                step();
            end else begin
                fell = 1'b1;
            end
        end
        checks++;
        if (fell !== 1'b1) begin
            errors++;
            $display("FAIL alarm_timeout: alarm still high after 40 cycles, expected drop");
        end
        checks++;
        if (high != 12 || ticks != 3) begin
            errors++;
            $display("FAIL alarm_length: got %0d cycles %0d ticks expected 12 cycles 3 ticks", high, ticks);
        end
    endtask

    task automatic test_alarm_disable();
        reach_alarm();
        step();
        step();
        alarm_en = 1'b0;
        step();
        checks++;
        if (alarm !== 1'b0) begin
            errors++;
            $display("FAIL alarm_disable: got %b expected 0", alarm);
        end
        step();
        checks++;
        if (alarm !== 1'b0) begin
            errors++;
            $display("FAIL alarm_stays_off: got %b expected 0", alarm);
        end
    endtask

    task automatic test_reset_midcount();
        alarm_en = 1'b1;
        reach_alarm();
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (alarm !== 1'b1 || sec_tick !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: got alarm=%b tick=%b expected 1 1", alarm, sec_tick);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (disp_time !== 24'h235959 || sec_tick !== 1'b0 || alarm !== 1'b0 || set_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got disp=%h tick=%b alarm=%b err=%b expected 235959 0 0 0",
                     disp_time, sec_tick, alarm, set_err);
        end
        spring_szn = 1'b1;
        step();
        checks++;
        if (disp_time !== 24'h235959) begin
            errors++;
            $display("FAIL reset_hold: got %h expected 235959", disp_time);
        end
        reset = 1'b1;
        step();
        checks++;
        if (disp_time !== 24'h005959) begin
            errors++;
            $display("FAIL release_dst_rise: got %h expected 005959", disp_time);
        end
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (disp_time !== 24'h010000 || sec_tick !== 1'b1) begin
            errors++;
            $display("FAIL release_first_tick: got %h tick=%b expected 010000 1", disp_time, sec_tick);
        end
    endtask

    initial begin
        reset      = 1'b0;
        spring_szn = 1'b0;
        mode_12h   = 1'b0;
        set_en     = 1'b0;
        set_time   = 24'h000000;
        alarm_en   = 1'b0;
        alarm_time = 24'h000000;
        test_reset();
        test_dst();
        test_dst_tick();
        test_12h();
        test_set();
        test_alarm();
        test_alarm_disable();
        test_reset_midcount();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
